// File: rtl/hyperbus_w2phy.sv
// AXI W beat to PHY TX word packer: merges narrow/unaligned beats into 2*NumPhys-byte words.
// Optional W-last consistency check enabled by defining HYPERBUS_W2PHY_LAST_CHECK_EN.
module hyperbus_w2phy #(
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned NumPhys      = 2,
    parameter int unsigned BurstLength  = 8,
    parameter int unsigned AddrWidth    = $clog2(AxiDataWidth / 8)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [2:0]                  size,
    input  logic                        is_a_write,
    input  logic                        trans_handshake,
    input  logic [AddrWidth-1:0]        start_addr,
    input  logic [BurstLength-1:0]      burst_len,
    input  logic                        axi_valid_i,
    output logic                        axi_ready_o,
    input  logic [AxiDataWidth-1:0]     axi_data_i,
    input  logic [AxiDataWidth/8-1:0]   axi_strb_i,
    input  logic                        axi_last_i,
    output logic                        phy_valid_o,
    input  logic                        phy_ready_i,
    output logic [16*NumPhys-1:0]       data_o,
    output logic [2*NumPhys-1:0]        strb_o,
    output logic                        last_o,
    output logic                        error_o
);

    localparam int unsigned PhyBytes = 2 * NumPhys;
    localparam logic [BurstLength-1:0] PhyBytesL = BurstLength'(PhyBytes);
    localparam logic [BurstLength-1:0] PhyMask   = ~(PhyBytesL - BurstLength'(1));

    typedef enum logic [1:0] {StIdle, StAccept, StMerge, StEmit} state_e;

    state_e                      r_state;
    logic [2:0]                  r_size;
    logic [BurstLength-1:0]      r_axi_addr;
    logic [BurstLength-1:0]      r_phy_base;
    logic [BurstLength-1:0]      r_beat_cnt;
    logic [BurstLength-1:0]      r_burst_len;
    logic [AxiDataWidth-1:0]     r_beat_data;
    logic [AxiDataWidth/8-1:0]   r_beat_strb;
    logic [16*NumPhys-1:0]       r_asm_data;
    logic [2*NumPhys-1:0]        r_asm_strb;
    logic                        r_axi_ready;
    logic                        r_phy_valid;
    logic                        r_last;

    logic [BurstLength-1:0]      w_start;
    logic [BurstLength-1:0]      w_beat_bytes;
    logic [BurstLength-1:0]      w_hi;
    logic [BurstLength-1:0]      w_span;
    logic [BurstLength-1:0]      w_dist;
    logic                        w_final;
    logic                        w_remain;
    logic [BurstLength-1:0]      w_byte_addr;
    logic [BurstLength-1:0]      w_byte_off;
    logic [AddrWidth-1:0]        w_lane;
    logic [16*NumPhys-1:0]       w_merge_data;
    logic [2*NumPhys-1:0]        w_merge_strb;

    assign w_start      = BurstLength'(start_addr);
    assign w_beat_bytes = BurstLength'(1) << r_size;
    assign w_hi         = (r_axi_addr & ~(w_beat_bytes - BurstLength'(1))) + w_beat_bytes;
    assign w_span       = w_hi - r_axi_addr;
    // Distances are taken modulo 2^BurstLength so a burst ending at the wrap point still frames.
    assign w_dist       = w_hi - r_phy_base;
    assign w_final      = (r_beat_cnt == r_burst_len);
    assign w_remain     = (w_dist > PhyBytesL);

    always_comb begin
        w_merge_data = r_asm_data;
        w_merge_strb = r_asm_strb;
        w_byte_addr  = '0;
        w_byte_off   = '0;
        w_lane       = '0;
        for (int k = 0; k < PhyBytes; k++) begin
            w_byte_addr = r_phy_base + BurstLength'(k);
            w_byte_off  = w_byte_addr - r_axi_addr;
            w_lane      = w_byte_addr[AddrWidth-1:0];
            if (w_byte_off < w_span) begin
                w_merge_data[8*k +: 8] = r_beat_data[8*w_lane +: 8];
                w_merge_strb[k]        = r_beat_strb[w_lane];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_size      <= '0;
            r_axi_addr  <= '0;
            r_phy_base  <= '0;
            r_beat_cnt  <= '0;
            r_burst_len <= '0;
            r_beat_data <= '0;
            r_beat_strb <= '0;
            r_asm_data  <= '0;
            r_asm_strb  <= '0;
            r_axi_ready <= 1'b0;
            r_phy_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (trans_handshake && is_a_write) begin
                        r_size      <= size;
                        r_axi_addr  <= w_start;
                        r_phy_base  <= w_start & PhyMask;
                        r_burst_len <= burst_len;
                        r_beat_cnt  <= '0;
                        r_asm_data  <= '0;
                        r_asm_strb  <= '0;
                        r_axi_ready <= 1'b1;
                        r_state     <= StAccept;
                    end
                end
                StAccept: begin
                    if (axi_valid_i) begin
                        r_beat_data <= axi_data_i;
                        r_beat_strb <= axi_strb_i;
                        r_axi_ready <= 1'b0;
                        r_state     <= StMerge;
                    end
                end
                StMerge: begin
                    r_asm_data <= w_merge_data;
                    r_asm_strb <= w_merge_strb;
                    if (w_dist >= PhyBytesL || w_final) begin
                        r_phy_valid <= 1'b1;
                        r_last      <= w_final && !w_remain;
                        r_state     <= StEmit;
                    end else begin
                        r_axi_addr  <= w_hi;
                        r_beat_cnt  <= r_beat_cnt + BurstLength'(1);
                        r_axi_ready <= 1'b1;
                        r_state     <= StAccept;
                    end
                end
                StEmit: begin
                    if (phy_ready_i) begin
                        r_phy_valid <= 1'b0;
                        r_last      <= 1'b0;
                        r_phy_base  <= r_phy_base + PhyBytesL;
                        r_asm_data  <= '0;
                        r_asm_strb  <= '0;
                        if (w_remain) begin
                            r_state <= StMerge;
                        end else if (w_final) begin
                            r_state <= StIdle;
                        end else begin
                            r_axi_addr  <= w_hi;
                            r_beat_cnt  <= r_beat_cnt + BurstLength'(1);
                            r_axi_ready <= 1'b1;
                            r_state     <= StAccept;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign axi_ready_o = r_axi_ready;
    assign phy_valid_o = r_phy_valid;
    assign data_o      = r_asm_data;
    assign strb_o      = r_asm_strb;
    assign last_o      = r_last;

`ifdef HYPERBUS_W2PHY_LAST_CHECK_EN
    logic r_error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (r_state == StAccept) && axi_valid_i && (axi_last_i != w_final);
        end
    end

    assign error_o = r_error;
`else
    logic w_unused;
    assign w_unused = axi_last_i;
    assign error_o  = 1'b0;
`endif

endmodule
